// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Registered ALU with a valid/ready handshake on both sides.
//               It accepts one operation at a time. Logic and arithmetic ops
//               complete in one cycle. Shifts run iteratively, one bit per
//               cycle. The result and the {n,z,c,v} flags are held until the
//               consumer accepts them.
//
//               Optional build macro ALU_ROTATE_EN enables ROL (4'b1000) and
//               ROR (4'b1001). Without it both codes are illegal and no rotate
//               logic is built.
//
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   operands/op valid       in_ready  ready to accept
//               op[3:0]    operation select
//               a[N-1:0]   operand A
//               b[N-1:0]   operand B, or the unsigned shift/rotate amount
//               out_valid  result/flags valid      out_ready consumer accepts
//               result     operation result        flags     {n, z, c, v}
//               err        an illegal op code was accepted
// Revision    : 1.0  initial release
// ============================================================================
module seq_alu #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         err
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_XOR = 4'b0010;
    localparam logic [3:0] c_OP_ADD = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0100;
    localparam logic [3:0] c_OP_SHL = 4'b0101;
    localparam logic [3:0] c_OP_SHR = 4'b0110;
    localparam logic [3:0] c_OP_SRA = 4'b0111;
`ifdef ALU_ROTATE_EN
    localparam logic [3:0] c_OP_ROL = 4'b1000;
    localparam logic [3:0] c_OP_ROR = 4'b1001;
`endif

    localparam logic [N-1:0]  c_N_B  = N'(N);
    localparam logic [CW-1:0] c_N_CW = CW'(N);
    localparam logic [CW-1:0] c_ONE  = CW'(1);

    logic [1:0]    r_state;
    logic [3:0]    r_op;
    logic [N-1:0]  r_work;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_result;
    logic [3:0]    r_flags;
    logic          r_err;

    logic [N:0]    w_sum;
    logic [N:0]    w_diff;
    logic [N-1:0]  w_res;
    logic          w_c;
    logic          w_v;
    logic          w_err;
    logic          w_is_shift;
    logic [CW-1:0] w_amt;
    logic [N-1:0]  w_next;
    logic          w_out_bit;

    // SUB is computed as a + ~b + 1, so its carry-out means a >= b unsigned.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);

    // Single-cycle ops, evaluated on the operands being presented.
    always_comb begin
        w_res      = '0;
        w_c        = 1'b0;
        w_v        = 1'b0;
        w_err      = 1'b0;
        w_is_shift = 1'b0;
        case (op)
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_ADD: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff[N-1:0];
                w_c   = w_diff[N];
                w_v   = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
            end
            c_OP_SHL, c_OP_SHR, c_OP_SRA: w_is_shift = 1'b1;
`ifdef ALU_ROTATE_EN
            c_OP_ROL, c_OP_ROR:           w_is_shift = 1'b1;
`endif
            default:  w_err = 1'b1;
        endcase
    end

    // Iteration count: shifts saturate at N steps; rotates use b mod N.
    always_comb begin
        w_amt = (b >= c_N_B) ? c_N_CW : CW'(b);
`ifdef ALU_ROTATE_EN
        if (op[3]) begin
            w_amt = CW'(b % c_N_B);
        end
`endif
    end

    // One step of the iterative shifter and the bit that falls out of it.
    always_comb begin
        w_next    = r_work;
        w_out_bit = 1'b0;
        case (r_op)
            c_OP_SHL: begin
                w_next    = {r_work[N-2:0], 1'b0};
                w_out_bit = r_work[N-1];
            end
            c_OP_SHR: begin
                w_next    = {1'b0, r_work[N-1:1]};
                w_out_bit = r_work[0];
            end
            c_OP_SRA: begin
                w_next    = {r_work[N-1], r_work[N-1:1]};
                w_out_bit = r_work[0];
            end
`ifdef ALU_ROTATE_EN
            c_OP_ROL: begin
                w_next    = {r_work[N-2:0], r_work[N-1]};
                w_out_bit = r_work[N-1];
            end
            c_OP_ROR: begin
                w_next    = {r_work[0], r_work[N-1:1]};
                w_out_bit = r_work[0];
            end
`endif
            default: begin
                w_next    = r_work;
                w_out_bit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_op     <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op  <= op;
                        r_err <= w_err;
                        if (w_is_shift) begin
                            r_work <= a;
                            r_cnt  <= w_amt;
                            if (w_amt == '0) begin
                                // Zero-count shift/rotate passes a through with c=0.
                                r_result <= a;
                                r_flags  <= {a[N-1], (a == '0), 2'b00};
                                r_state  <= c_DONE;
                            end else begin
                                r_state  <= c_SHIFT;
                            end
                        end else begin
                            // Illegal codes leave w_res/w_c/w_v at 0, so every flag is 0.
                            r_result <= w_res;
                            r_flags  <= {w_res[N-1], (w_res == '0) & ~w_err, w_c, w_v};
                            r_state  <= c_DONE;
                        end
                    end
                end
                c_SHIFT: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        r_result <= w_next;
                        r_flags  <= {w_next[N-1], (w_next == '0), w_out_bit, 1'b0};
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign result    = r_result;
    assign flags     = r_flags;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (N=4). Table-driven vectors
//               feed a scoreboard queue. Hand-written sequences cover
//               backpressure and asynchronous reset in the middle of a shift.
//               Rotate expectations follow ALU_ROTATE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_alu;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic         err;

    seq_alu #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] flg;
        logic       err;
        int         lat;
    } vec_t;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flg;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Drive one op, wait for out_valid, compare against the scoreboard entry,
    // then release the result.
    task automatic run_op(input vec_t v);
        exp_t e;
        int   lat;
        bit   ready_low;
        e = '{v.res, v.flg, v.err, v.lat};
        sb.push_back(e);
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) ready_low = 1'b0;
        end while (!out_valid && lat < 40);
        e = sb.pop_front();
        if (!out_valid) begin
            chk($sformatf("op%0h timeout", v.op), 0, 1);
        end else begin
            chk($sformatf("op%0h a%0h b%0h result", v.op, v.a, v.b), int'(result), int'(e.res));
            chk($sformatf("op%0h a%0h b%0h flags", v.op, v.a, v.b), int'(flags), int'(e.flg));
            chk($sformatf("op%0h a%0h b%0h err", v.op, v.a, v.b), int'(err), int'(e.err));
            chk($sformatf("op%0h a%0h b%0h latency", v.op, v.a, v.b), lat, e.lat);
            chk($sformatf("op%0h in_ready low while busy", v.op), int'(ready_low), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("op%0h back to idle", v.op), int'({in_ready, out_valid}), 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //            op     a      b      res    flags    err  lat
        vecs[0]  = '{4'h3, 4'h7, 4'h1, 4'h8, 4'b1001, 1'b0, 1};  // ADD overflow
        vecs[1]  = '{4'h4, 4'h3, 4'h5, 4'hE, 4'b1000, 1'b0, 1};  // SUB borrow
        vecs[2]  = '{4'h4, 4'h5, 4'h5, 4'h0, 4'b0110, 1'b0, 1};  // SUB equal
        vecs[3]  = '{4'h0, 4'hC, 4'hA, 4'h8, 4'b1000, 1'b0, 1};  // AND
        vecs[4]  = '{4'h1, 4'h5, 4'hA, 4'hF, 4'b1000, 1'b0, 1};  // OR
        vecs[5]  = '{4'h2, 4'hA, 4'h6, 4'hC, 4'b1000, 1'b0, 1};  // XOR
        vecs[6]  = '{4'h3, 4'hF, 4'h1, 4'h0, 4'b0110, 1'b0, 1};  // ADD carry, no v
        vecs[7]  = '{4'h5, 4'hB, 4'h2, 4'hC, 4'b1000, 1'b0, 3};  // SHL 2
        vecs[8]  = '{4'h7, 4'h8, 4'h7, 4'hF, 4'b1010, 1'b0, 5};  // SRA saturated
        vecs[9]  = '{4'h6, 4'hF, 4'h3, 4'h1, 4'b0010, 1'b0, 4};  // SHR 3
        vecs[10] = '{4'h5, 4'h5, 4'h0, 4'h5, 4'b0000, 1'b0, 1};  // SHL by 0
        vecs[11] = '{4'h6, 4'h9, 4'hF, 4'h0, 4'b0110, 1'b0, 5};  // SHR saturated
        vecs[12] = '{4'h4, 4'h8, 4'h1, 4'h7, 4'b0011, 1'b0, 1};  // SUB overflow
        vecs[13] = '{4'hF, 4'h3, 4'h3, 4'h0, 4'b0000, 1'b1, 1};  // illegal
`ifdef ALU_ROTATE_EN
        vecs[14] = '{4'h8, 4'h9, 4'h1, 4'h3, 4'b0010, 1'b0, 2};  // ROL 1
        vecs[15] = '{4'h9, 4'h1, 4'h5, 4'h8, 4'b1010, 1'b0, 2};  // ROR 5 mod 4
        vecs[16] = '{4'h8, 4'h6, 4'h4, 4'h6, 4'b0000, 1'b0, 1};  // ROL 4 mod 4 = 0
`else
        vecs[14] = '{4'h8, 4'h9, 4'h1, 4'h0, 4'b0000, 1'b1, 1};
        vecs[15] = '{4'h9, 4'h1, 4'h5, 4'h0, 4'b0000, 1'b1, 1};
        vecs[16] = '{4'h8, 4'h6, 4'h4, 4'h0, 4'b0000, 1'b1, 1};
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset result/flags/err", int'({result, flags, err}), 0);

        for (int i = 0; i < 17; i++) run_op(vecs[i]);

        // Backpressure: the result is held, and in_valid is ignored in DONE
        // and on the release edge.
        @(negedge clk);
        op = 4'h2; a = 4'hA; b = 4'h6; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp cycle%0d out_valid", i), int'(out_valid), 1);
            chk($sformatf("bp cycle%0d result", i), int'(result), 32'hC);
            chk($sformatf("bp cycle%0d flags", i), int'(flags), 32'b1000);
            chk($sformatf("bp cycle%0d in_ready", i), int'(in_ready), 0);
            if (i == 1) begin op = 4'h0; a = 4'h0; b = 4'h0; in_valid = 1'b1; end
            if (i == 2) in_valid = 1'b0;
            if (i == 3) begin op = 4'h0; a = 4'hF; b = 4'hF; in_valid = 1'b1; out_ready = 1'b1; end
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp release idle", int'({in_ready, out_valid}), 2);
        chk("bp result held", int'(result), 32'hC);
        in_valid = 1'b0;

        // Asynchronous reset in the second cycle of SHR F,3.
        @(negedge clk);
        op = 4'h6; a = 4'hF; b = 4'h3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", int'(out_valid), 0);
        chk("midreset result", int'(result), 0);
        chk("midreset in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postreset in_ready", int'(in_ready), 1);
        v = '{4'h0, 4'hC, 4'hA, 4'h8, 4'b1000, 1'b0, 1};
        run_op(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
